// File: rtl/seq_control.sv
// Timed Gray-code sequencer for the B1:B0 lamp/actuator pair.
// A start in idle launches a run of NSTEPS codes, each held for DWELL cycles.
// Stop aborts the run without a done pulse. Every output is a flop.
module seq_control #(
    parameter int unsigned DWELL  = 3,  // cycles per code, 1..255
    parameter int unsigned NSTEPS = 8   // codes per run, 1..255
) (
    input  logic inputClk,
    input  logic inputReset,
    input  logic inputStart,
    input  logic inputStop,
    input  logic inputDir,
    output logic outputB0,
    output logic outputB1,
    output logic outputBusy,
    output logic outputDone
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    localparam logic [7:0] DwellLast = 8'(DWELL - 1);
    localparam logic [7:0] StepLast  = 8'(NSTEPS);

    state_t     state;
    logic [1:0] code;
    logic [7:0] dwellCnt;
    logic [7:0] stepCnt;
    logic       dirLatched;

    // Gray successor: forward 01->11->10->00, reverse 10->11->01->00.
    function automatic logic [1:0] nextCode(input logic [1:0] cur, input logic fwd);
        logic [1:0] nxt;
        nxt = 2'b00;
        if (fwd) begin
            unique case (cur)
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                2'b10:   nxt = 2'b00;
                default: nxt = 2'b01;
            endcase
        end else begin
            unique case (cur)
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                2'b01:   nxt = 2'b00;
                default: nxt = 2'b10;
            endcase
        end
        return nxt;
    endfunction

    // FSM, counters and registered outputs; reset takes priority over everything.
    always_ff @(posedge inputClk) begin
        if (!inputReset) begin
            state      <= StIdle;
            code       <= 2'b00;
            dwellCnt   <= 8'd0;
            stepCnt    <= 8'd0;
            dirLatched <= 1'b1;
            outputB0   <= 1'b0;
            outputB1   <= 1'b0;
            outputBusy <= 1'b0;
            outputDone <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    // Stop is deliberately not looked at here.
                    if (inputStart) begin
                        state      <= StRun;
                        dirLatched <= inputDir;
                        code       <= inputDir ? 2'b01 : 2'b10;
                        dwellCnt   <= DwellLast;
                        stepCnt    <= 8'd1;
                        outputB1   <= ~inputDir;
                        outputB0   <= inputDir;
                        outputBusy <= 1'b1;
                    end else begin
                        outputB1   <= 1'b0;
                        outputB0   <= 1'b0;
                        outputBusy <= 1'b0;
                    end
                    outputDone <= 1'b0;
                end

                StRun: begin
                    if (inputStop) begin
                        state      <= StIdle;
                        code       <= 2'b00;
                        outputB1   <= 1'b0;
                        outputB0   <= 1'b0;
                        outputBusy <= 1'b0;
                    end else if (dwellCnt != 8'd0) begin
                        dwellCnt <= dwellCnt - 8'd1;
                    end else if (stepCnt == StepLast) begin
                        // Last code stays on the pins during the done cycle.
                        state      <= StDone;
                        outputBusy <= 1'b0;
                        outputDone <= 1'b1;
                    end else begin
                        code     <= nextCode(code, dirLatched);
                        {outputB1, outputB0} <= nextCode(code, dirLatched);
                        dwellCnt <= DwellLast;
                        stepCnt  <= stepCnt + 8'd1;
                    end
                end

                StDone: begin
                    state      <= StIdle;
                    code       <= 2'b00;
                    outputB1   <= 1'b0;
                    outputB0   <= 1'b0;
                    outputBusy <= 1'b0;
                    outputDone <= 1'b0;
                end

                default: begin
                    state      <= StIdle;
                    code       <= 2'b00;
                    outputB1   <= 1'b0;
                    outputB0   <= 1'b0;
                    outputBusy <= 1'b0;
                    outputDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control: expected per-cycle outputs are queued as
// stimulus is applied and popped/compared one time unit after each rising edge.
module tb_seq_control;

    typedef struct packed {
        logic [1:0] b;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic startA, stopA, dirA, b0A, b1A, busyA, doneA;
    logic startB, stopB, dirB, b0B, b1B, busyB, doneB;

    // Main configuration used by the run/abort/reset scenarios.
    seq_control #(.DWELL(2), .NSTEPS(5)) dutA (
        .inputClk   (clk),
        .inputReset (rstN),
        .inputStart (startA),
        .inputStop  (stopA),
        .inputDir   (dirA),
        .outputB0   (b0A),
        .outputB1   (b1A),
        .outputBusy (busyA),
        .outputDone (doneA)
    );

    // Minimal configuration for the DWELL = NSTEPS = 1 corner.
    seq_control #(.DWELL(1), .NSTEPS(1)) dutB (
        .inputClk   (clk),
        .inputReset (rstN),
        .inputStart (startB),
        .inputStop  (stopB),
        .inputDir   (dirB),
        .outputB0   (b0B),
        .outputB1   (b1B),
        .outputBusy (busyB),
        .outputDone (doneB)
    );

    obs_t  expA[$];
    string tagA[$];
    obs_t  expB[$];
    string tagB[$];
    int    total = 0;
    int    bad   = 0;

    logic [1:0] fwdSeq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] revSeq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

    task automatic pushA(input logic [1:0] b, input logic busy, input logic done,
                         input string tag);
        expA.push_back('{b: b, busy: busy, done: done});
        tagA.push_back(tag);
    endtask

    task automatic pushB(input logic [1:0] b, input logic busy, input logic done,
                         input string tag);
        expB.push_back('{b: b, busy: busy, done: done});
        tagB.push_back(tag);
    endtask

    // Queue nCodes Gray codes for DUT A, each visible for two cycles.
    task automatic pushRunA(input bit fwd, input int nCodes, input string tag);
        for (int i = 0; i < nCodes; i++) begin
            logic [1:0] c;
            c = fwd ? fwdSeq[i % 4] : revSeq[i % 4];
            pushA(c, 1'b1, 1'b0, tag);
            pushA(c, 1'b1, 1'b0, tag);
        end
    endtask

    task automatic compare(input obs_t o, input obs_t e, input string tag);
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // One clock: step past the edge, then check whichever queues hold an entry.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (expA.size() != 0) compare({b1A, b0A, busyA, doneA}, expA.pop_front(), tagA.pop_front());
        if (expB.size() != 0) compare({b1B, b0B, busyB, doneB}, expB.pop_front(), tagB.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rstN = 1'b0;
        startA = 1'b1; stopA = 1'b0; dirA = 1'b1;
        startB = 1'b1; stopB = 1'b0; dirB = 1'b1;

        // Reset held with start high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            pushA(2'b00, 1'b0, 1'b0, "reset");
            pushB(2'b00, 1'b0, 1'b0, "reset");
            cycle();
        end
        rstN = 1'b1; startA = 1'b0; startB = 1'b0;
        pushA(2'b00, 1'b0, 1'b0, "idle");
        pushB(2'b00, 1'b0, 1'b0, "idle");
        cycle();

        // Forward run.
        startA = 1'b1; dirA = 1'b1;
        pushRunA(1'b1, 5, "fwd_run");
        pushA(2'b01, 1'b0, 1'b1, "fwd_done");
        pushA(2'b00, 1'b0, 1'b0, "fwd_idle");
        cycle();
        startA = 1'b0;
        repeat (11) cycle();

        // Reverse run; dir toggles and a stray start mid-run are ignored.
        startA = 1'b1; dirA = 1'b0;
        pushRunA(1'b0, 5, "rev_run");
        pushA(2'b10, 1'b0, 1'b1, "rev_done");
        pushA(2'b00, 1'b0, 1'b0, "rev_idle");
        cycle();
        for (int i = 0; i < 11; i++) begin
            dirA = ~dirA;
            startA = (i == 3);
            cycle();
        end
        startA = 1'b0;

        // Abort on the 4th RUN cycle.
        dirA = 1'b1; startA = 1'b1;
        pushRunA(1'b1, 2, "abort_run");
        pushA(2'b00, 1'b0, 1'b0, "abort_idle");
        pushA(2'b00, 1'b0, 1'b0, "abort_idle");
        pushA(2'b00, 1'b0, 1'b0, "abort_idle");
        cycle();
        startA = 1'b0;
        repeat (3) cycle();
        stopA = 1'b1;
        cycle();
        stopA = 1'b0;
        repeat (2) cycle();

        // Start and stop together in idle: run starts fresh and completes.
        startA = 1'b1; stopA = 1'b1;
        pushRunA(1'b1, 5, "restart_run");
        pushA(2'b01, 1'b0, 1'b1, "restart_done");
        pushA(2'b00, 1'b0, 1'b0, "restart_idle");
        cycle();
        startA = 1'b0; stopA = 1'b0;
        repeat (11) cycle();

        // Stop on the final dwell cycle beats completion.
        startA = 1'b1;
        pushRunA(1'b1, 5, "laststop_run");
        pushA(2'b00, 1'b0, 1'b0, "laststop_nodone");
        pushA(2'b00, 1'b0, 1'b0, "laststop_idle");
        cycle();
        startA = 1'b0;
        repeat (9) cycle();
        stopA = 1'b1;
        cycle();
        stopA = 1'b0;
        cycle();

        // Reset during the 3rd code of a reverse run, then a forward run.
        startA = 1'b1; dirA = 1'b0;
        pushRunA(1'b0, 2, "midrst_run");
        pushA(2'b01, 1'b1, 1'b0, "midrst_run");
        pushA(2'b00, 1'b0, 1'b0, "midrst_reset");
        cycle();
        startA = 1'b0;
        repeat (4) cycle();
        rstN = 1'b0;
        cycle();
        rstN = 1'b1;
        startA = 1'b1; dirA = 1'b1;
        pushRunA(1'b1, 5, "postrst_run");
        pushA(2'b01, 1'b0, 1'b1, "postrst_done");
        pushA(2'b00, 1'b0, 1'b0, "postrst_idle");
        cycle();
        startA = 1'b0;
        repeat (11) cycle();

        // DWELL = NSTEPS = 1 with start held: RUN, DONE, IDLE repeating.
        startB = 1'b1; dirB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushB(2'b01, 1'b1, 1'b0, "min_run");
            pushB(2'b01, 1'b0, 1'b1, "min_done");
            pushB(2'b00, 1'b0, 1'b0, "min_idle");
        end
        repeat (12) cycle();
        startB = 1'b0;

        // Every queued expectation must have been consumed.
        total++;
        assert (expA.size() + expB.size() == 0)
        else begin
            bad++;
            $error("FAIL drain observed=%0d expected=0", expA.size() + expB.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
